mul_top: RTL and testbench

MUL_TOP -- requirements
Module: mul_top

---
 rtl/mul_top.sv | 82 ++++++++
 tb/tb_mul_top.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_top.sv
// Single-cycle signed multiplier: radix-4 Booth partial products, carry-save
// reduction, one carry-propagate add, registered product with a valid flag.
module mul_top #(
  parameter int XLEN = 32
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     Multiplier,
  input  logic [XLEN-1:0]     Multiplicand,
  output logic                out_valid,
  output logic [2*XLEN-1:0]   Product
);

  localparam int PW  = 2 * XLEN;
  localparam int NPP = XLEN / 2;

  logic [XLEN:0]   rec_bits;
  logic [PW-1:0]   m_pos;
  logic [PW-1:0]   m_neg;
  logic [PW-1:0]   m2_pos;
  logic [PW-1:0]   m2_neg;
  logic [PW-1:0]   pp [NPP];
  logic [PW-1:0]   cs_sum;
  logic [PW-1:0]   cs_carry;
  logic [PW-1:0]   product_next;

  // Implicit zero below bit 0 seeds the first Booth group.
  assign rec_bits = {Multiplier, 1'b0};

  // All multiples live at full product width, so -2M of the most-negative
  // operand (+2^XLEN) is still representable.
  assign m_pos  = {{XLEN{Multiplicand[XLEN-1]}}, Multiplicand};
  assign m_neg  = -m_pos;
  assign m2_pos = m_pos << 1;
  assign m2_neg = m_neg << 1;

  for (genvar g = 0; g < NPP; g++) begin : g_booth
    logic [2:0]    grp;
    logic [PW-1:0] sel;

    assign grp = rec_bits[2*g+2 : 2*g];
    assign sel = (grp == 3'b001 || grp == 3'b010) ? m_pos  :
                 (grp == 3'b011)                  ? m2_pos :
                 (grp == 3'b100)                  ? m2_neg :
                 (grp == 3'b101 || grp == 3'b110) ? m_neg  :
                                                    '0;
    assign pp[g] = sel << (2 * g);
  end

  // 3:2 compressors fold each partial product into a redundant sum/carry pair;
  // bits carried past the top are dropped since the true product fits in PW.
  always_comb begin
    logic [PW-1:0] t_sum;
    logic [PW-1:0] t_carry;
    cs_sum   = '0;
    cs_carry = '0;
    t_sum    = '0;
    t_carry  = '0;
    for (int i = 0; i < NPP; i++) begin
      t_sum    = cs_sum ^ cs_carry ^ pp[i];
      t_carry  = ((cs_sum & cs_carry) | (cs_sum & pp[i]) | (cs_carry & pp[i])) << 1;
      cs_sum   = t_sum;
      cs_carry = t_carry;
    end
  end

  assign product_next = cs_sum + cs_carry;

  always_ff @(posedge CLK) begin
    if (rst) begin
      out_valid <= 1'b0;
      Product   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Product <= product_next;
      end
    end
  end

endmodule

// File: tb/tb_mul_top.sv
// Scoreboard bench for mul_top: driver queues expected products, a negedge
// monitor pops on out_valid and checks the held value otherwise.
module tb_mul_top;

  logic        CLK;
  logic        rst;
  logic        in_valid;
  logic [31:0] mplier;
  logic [31:0] mcand;
  logic        out_valid;
  logic [63:0] product;

  logic [63:0] sb_q [$];
  logic [63:0] exp_hold;
  logic        mon_en;
  int          n_checks;
  int          n_fail;

  mul_top #(.XLEN(32)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .in_valid     (in_valid),
    .Multiplier   (mplier),
    .Multiplicand (mcand),
    .out_valid    (out_valid),
    .Product      (product)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    exp_hold = 64'h0;
    mon_en   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
  end

  always @(posedge CLK) begin
    mon_en = 1'b1;
    if (rst === 1'b1) exp_hold = 64'h0;
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      n_checks++;
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_valid: out_valid=1 product=%h, required no result", product);
        end else begin
          exp_hold = sb_q.pop_front();
          if (product !== exp_hold) begin
            n_fail++;
            $display("FAIL product: got %h, required %h", product, exp_hold);
          end
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL out_valid_x: got %b, required 0 or 1", out_valid);
      end else if (product !== exp_hold) begin
        n_fail++;
        $display("FAIL hold: got %h, required %h", product, exp_hold);
      end
    end
  end

  task automatic drive(input logic v, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    @(posedge CLK);
    #1;
    in_valid = v;
    rst      = r;
    mplier   = a;
    mcand    = b;
    if (v && !r) sb_q.push_back(exp);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    drive(1'b1, 1'b0, a, b, exp);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0);
  endtask

  initial begin
    logic [31:0]        ra;
    logic [31:0]        rb;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    rst      = 1'b1;
    in_valid = 1'b0;
    mplier   = 32'h0;
    mcand    = 32'h0;
    drive(1'b0, 1'b1, 32'h0, 32'h0, 64'h0);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 64'h0);

    // first edge after reset release accepts operands
    send(32'h8000_0000, 32'h8000_0001, 64'h3FFF_FFFF_8000_0000);
    send(32'hFFFE_FFFF, 32'hFFEF_FFFF, 64'h0000_0010_0011_0001);
    send(32'hFFFF_FFFF, 32'h0000_0000, 64'h0);
    send(32'h0000_0000, 32'h8000_0000, 64'h0);
    send(32'd10, 32'd6,  64'd60);
    send(32'd5,  32'd5,  64'd25);
    send(32'd5,  32'd10, 64'd50);
    send(32'd5,  32'd70, 64'd350);
    idle();
    send(32'd5,  32'd50, 64'd250);
    send(32'd5,  32'd40, 64'd200);
    send(32'hFFFF_FFFF, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB);
    send(32'd5, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB);
    send(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    send(32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    send(32'h0000_0001, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    send(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    idle();
    idle();

    // reset together with in_valid discards the operands
    send(32'd7, 32'd9, 64'd63);
    drive(1'b1, 1'b1, 32'd123, 32'd456, 64'h0);
    send(32'd3, 32'd4, 64'd12);
    // reset right after a valid cycle clears the result
    send(32'd11, 32'd13, 64'd143);
    drive(1'b0, 1'b1, 32'd0, 32'd0, 64'h0);
    send(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    idle();

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = {{32{ra[31]}}, ra};
      sb = {{32{rb[31]}}, rb};
      send(ra, rb, sa * sb);
      if (i % 15 == 14) begin
        idle();
        idle();
      end
    end
    idle();
    idle();
    idle();

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results never presented, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
